// File: rtl/freq_meter_gated.sv
// freq_meter_gated: gated-window frequency meter for a sampled waveform.
// A hysteresis comparator around midscale turns samples into a square
// signal; its rising edges are counted over GATE_CYCLES clocks and the
// saturating count is published at the end of each window.
// Optional feature macro: FREQ_METER_AVG_EN (freq_out becomes the floor
// mean of the last four window counts, overflow the OR of their sat flags).
//
// state   | meaning
// IDLE    | not measuring; comparator tracks, counters held at zero
// MEASURE | gate window running, rising edges counted
module freq_meter_gated #(
  parameter int          SAMPLE_W    = 8,
  parameter int          CNT_W       = 13,
  parameter int unsigned GATE_CYCLES = 32'd50_000_000,
  parameter int          HYST        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [CNT_W-1:0]    freq_out,
  output logic                freq_valid,
  output logic                overflow
);

  localparam int                  MID       = 1 << (SAMPLE_W - 1);
  localparam logic [SAMPLE_W-1:0] THR_HI    = SAMPLE_W'(MID + HYST);
  localparam logic [SAMPLE_W-1:0] THR_LO    = SAMPLE_W'(MID - HYST);
  localparam logic [31:0]         GATE_LAST = 32'(GATE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t             state_q, state_d;
  logic               sq_q, sq_d;
  logic [31:0]        gate_q, gate_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   freq_out_q, freq_out_d;
  logic               freq_valid_q, freq_valid_d;
  logic               overflow_q, overflow_d;

  logic               rise;
  logic [CNT_W-1:0]   cnt_inc;
  logic               sat_inc;
  logic               window_close;

`ifdef FREQ_METER_AVG_EN
  logic [3:0][CNT_W-1:0] hist_cnt_q, hist_cnt_d;
  logic [3:0]            hist_sat_q, hist_sat_d;
  logic [CNT_W+1:0]      hist_sum;
`endif

  // Hysteresis comparator, rising-edge detect and saturating increment.
  always_comb begin
    sq_d = sq_q;
    if (sample_valid) begin
      if (sample_in >= THR_HI) begin
        sq_d = 1'b1;
      end else if (sample_in < THR_LO) begin
        sq_d = 1'b0;
      end
    end
    rise = sq_d & ~sq_q;
    if (rise && (count_q == CNT_MAX)) begin
      cnt_inc = count_q;
      sat_inc = 1'b1;
    end else begin
      cnt_inc = count_q + {{(CNT_W-1){1'b0}}, rise};
      sat_inc = sat_q;
    end
    window_close = (state_q == MEASURE) && en && (gate_q == GATE_LAST);
  end

  // Next-state, window counters and result publication.
  always_comb begin
    state_d      = state_q;
    gate_d       = '0;
    count_d      = '0;
    sat_d        = 1'b0;
    freq_valid_d = 1'b0;
    freq_out_d   = freq_out_q;
    overflow_d   = overflow_q;
`ifdef FREQ_METER_AVG_EN
    hist_cnt_d   = hist_cnt_q;
    hist_sat_d   = hist_sat_q;
    hist_sum     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (en) state_d = MEASURE;
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (window_close) begin
          freq_valid_d = 1'b1;
`ifdef FREQ_METER_AVG_EN
          hist_cnt_d = {hist_cnt_q[2:0], cnt_inc};
          hist_sat_d = {hist_sat_q[2:0], sat_inc};
          hist_sum   = {2'b00, hist_cnt_d[0]} + {2'b00, hist_cnt_d[1]}
                     + {2'b00, hist_cnt_d[2]} + {2'b00, hist_cnt_d[3]};
          freq_out_d = hist_sum[CNT_W+1:2];
          overflow_d = |hist_sat_d;
`else
          freq_out_d = cnt_inc;
          overflow_d = sat_inc;
`endif
        end else begin
          gate_d  = gate_q + 32'd1;
          count_d = cnt_inc;
          sat_d   = sat_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sq_q         <= 1'b0;
      gate_q       <= '0;
      count_q      <= '0;
      sat_q        <= 1'b0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      hist_cnt_q   <= '0;
      hist_sat_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sq_q         <= sq_d;
      gate_q       <= gate_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
`ifdef FREQ_METER_AVG_EN
      hist_cnt_q   <= hist_cnt_d;
      hist_sat_q   <= hist_sat_d;
`endif
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter_gated.sv
// Directed bench for freq_meter_gated: square, threshold, sine-like and
// valid-gated waveforms; abort, reset and saturation (8-bit instance).
module tb_freq_meter_gated;

  localparam int GATE = 1000;

  logic        clk = 1'b0;
  logic        rst_n, en, sample_valid;
  logic [7:0]  sample_in;
  logic [12:0] f13;
  logic        v13, o13;
  logic [7:0]  f8;
  logic        v8, o8;

  freq_meter_gated #(.SAMPLE_W(8), .CNT_W(13), .GATE_CYCLES(GATE), .HYST(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_in(sample_in),
    .sample_valid(sample_valid), .freq_out(f13), .freq_valid(v13), .overflow(o13));

  freq_meter_gated #(.SAMPLE_W(8), .CNT_W(8), .GATE_CYCLES(GATE), .HYST(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_in(sample_in),
    .sample_valid(sample_valid), .freq_out(f8), .freq_valid(v8), .overflow(o8));

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] f13;
    logic        o13;
    logic [7:0]  f8;
    logic        o8;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          ncyc = 0;
  int          next_pulse_at = -1;
  int          ph = 0;
  int          mode = 0;
  logic        prev_v = 1'b0;
  logic [12:0] last_f13 = '0;
  logic        last_o13 = 1'b0;
  logic [7:0]  last_f8 = '0;
  logic        last_o8 = 1'b0;

`ifdef FREQ_METER_AVG_EN
  int h13[4], hs13[4], h8[4], hs8[4];
  task automatic hist_clear();
    for (int i = 0; i < 4; i++) begin
      h13[i] = 0; hs13[i] = 0; h8[i] = 0; hs8[i] = 0;
    end
  endtask
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, ncyc);
    end
  endtask

  // Expected result for one window given its raw counts and sat flags.
  task automatic push_exp(input int c13, input int s13, input int c8, input int s8);
    exp_t e;
`ifdef FREQ_METER_AVG_EN
    for (int i = 3; i > 0; i--) begin
      h13[i] = h13[i-1]; hs13[i] = hs13[i-1]; h8[i] = h8[i-1]; hs8[i] = hs8[i-1];
    end
    h13[0] = c13; hs13[0] = s13; h8[0] = c8; hs8[0] = s8;
    e.f13 = 13'((h13[0] + h13[1] + h13[2] + h13[3]) / 4);
    e.o13 = (hs13[0] | hs13[1] | hs13[2] | hs13[3]) != 0;
    e.f8  = 8'((h8[0] + h8[1] + h8[2] + h8[3]) / 4);
    e.o8  = (hs8[0] | hs8[1] | hs8[2] | hs8[3]) != 0;
`else
    e.f13 = 13'(c13);
    e.o13 = s13 != 0;
    e.f8  = 8'(c8);
    e.o8  = s8 != 0;
`endif
    q.push_back(e);
  endtask

  // Advance n cycles: check outputs on the falling edge, then drive the next sample.
  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ncyc++;
      if (v13 || v8) begin
        check("back_to_back_valid", {31'b0, prev_v}, 32'd0);
        check("pulse_expected", {31'b0, (q.size() != 0)}, 32'd1);
        check("pulse_time", ncyc, next_pulse_at);
        check("valid13", {31'b0, v13}, 32'd1);
        check("valid8", {31'b0, v8}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("freq13", {19'b0, f13}, {19'b0, e.f13});
          check("ovf13", {31'b0, o13}, {31'b0, e.o13});
          check("freq8", {24'b0, f8}, {24'b0, e.f8});
          check("ovf8", {31'b0, o8}, {31'b0, e.o8});
          last_f13 = e.f13; last_o13 = e.o13; last_f8 = e.f8; last_o8 = e.o8;
        end
        next_pulse_at += GATE;
      end
      prev_v = v13;
      sample_valid = 1'b1;
      case (mode)
        1: sample_in = ((ph % 100) < 50) ? 8'd255 : 8'd0;
        2: sample_in = ((ph % 2) == 0) ? 8'd255 : 8'd0;
        3: sample_in = ((ph % 10) < 5) ? 8'd132 : 8'd123;
        4: sample_in = ((ph % 10) < 5) ? 8'd131 : 8'd124;
        5: case (ph % 8)
             0: sample_in = 8'd127;
             1, 7: sample_in = 8'd128;
             2, 6: sample_in = 8'd129;
             3, 5: sample_in = 8'd130;
             default: sample_in = 8'd131;
           endcase
        6: begin
             sample_in    = ((ph % 2) == 0) ? 8'd255 : 8'd0;
             sample_valid = ((ph % 2) == 0);
           end
        default: sample_in = 8'd0;
      endcase
      ph++;
    end
  endtask

  task automatic run_phase(input int m, input int nwin, input int c13, input int c8, input int s8);
    en = 1'b0;
    next_pulse_at = -1;
    step(10);
    mode = m;
    ph = 0;
    step(30);
    en = 1'b1;
    next_pulse_at = ncyc + GATE + 1;
    for (int i = 0; i < nwin; i++) push_exp(c13, 0, c8, s8);
    step(nwin * GATE + 1);
    check("queue_drained", q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    sample_valid = 1'b1;
    sample_in = 8'd0;
`ifdef FREQ_METER_AVG_EN
    hist_clear();
`endif
    step(3);
    check("rst_freq13", {19'b0, f13}, 32'd0);
    check("rst_valid13", {31'b0, v13}, 32'd0);
    check("rst_ovf13", {31'b0, o13}, 32'd0);
    check("rst_freq8", {24'b0, f8}, 32'd0);
    check("rst_valid8", {31'b0, v8}, 32'd0);
    check("rst_ovf8", {31'b0, o8}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Square 0/255, period 100: ten edges per window.
    run_phase(1, 2, 10, 10, 0);

    // Abort at gate count ~500 for 20 cycles: outputs hold, no pulse.
    step(500);
    en = 1'b0;
    next_pulse_at = -1;
    step(20);
    check("abort_hold_freq13", {19'b0, f13}, {19'b0, last_f13});
    check("abort_hold_ovf13", {31'b0, o13}, {31'b0, last_o13});
    check("abort_hold_freq8", {24'b0, f8}, {24'b0, last_f8});
    en = 1'b1;
    next_pulse_at = ncyc + GATE + 1;
    push_exp(10, 0, 10, 0);
    step(GATE + 1);
    check("abort_queue_drained", q.size(), 32'd0);

    // One-cycle reset mid-window while the waveform is low.
    step(300);
    while ((ph % 100) != 60) step(1);
    rst_n = 1'b0;
    next_pulse_at = -1;
    step(1);
    check("midrst_freq13", {19'b0, f13}, 32'd0);
    check("midrst_valid13", {31'b0, v13}, 32'd0);
    check("midrst_ovf13", {31'b0, o13}, 32'd0);
    check("midrst_freq8", {24'b0, f8}, 32'd0);
    check("midrst_ovf8", {31'b0, o8}, 32'd0);
    rst_n = 1'b1;
`ifdef FREQ_METER_AVG_EN
    hist_clear();
`endif
    next_pulse_at = ncyc + GATE + 1;
    push_exp(10, 0, 10, 0);
    step(GATE + 1);
    check("midrst_queue_drained", q.size(), 32'd0);

    // Period 2: 500 edges, the 8-bit instance saturates.
    run_phase(2, 2, 500, 255, 1);
    // Exact threshold levels 132/123: every period counts.
    run_phase(3, 1, 100, 100, 0);
    // Just inside hysteresis 131/124: no edges.
    run_phase(4, 1, 0, 0, 0);
    // Sine-like 127..131: no edges.
    run_phase(5, 1, 0, 0, 0);
    // Only the high samples are qualified: no edges.
    run_phase(6, 1, 0, 0, 0);

    en = 1'b0;
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter_gated.md
FREQ_METER_GATED -- requirements
Module: freq_meter_gated

Interface
REQ-001 Parameter SAMPLE_W, default 8, width of unsigned input samples.
REQ-002 Parameter CNT_W, default 13, width of the edge counter and result.
REQ-003 Parameter GATE_CYCLES, default 50_000_000, gate window length in clk cycles (1 s at 50 MHz); legal range 2..2^32-1.
REQ-004 Parameter HYST, default 4, comparator hysteresis in LSBs around midscale; legal range 0..2^(SAMPLE_W-1)-1.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  1  measurement enable; low holds block idle.
REQ-008 sample_in  input  SAMPLE_W  unsigned waveform sample, midscale = 2^(SAMPLE_W-1).
REQ-009 sample_valid  input  1  qualifies sample_in for the current cycle.
REQ-010 freq_out  output  CNT_W  rising-edge count of the last completed window.
REQ-011 freq_valid  output  1  one-cycle pulse when freq_out updates.
REQ-012 overflow  output  1  set when the last completed window's count saturated.

Function
REQ-013 Comparator state sq SHALL update only on sample_valid cycles: set when sample_in >= MID+HYST; clear when sample_in < MID-HYST; otherwise hold.
REQ-014 A rising edge SHALL be sq changing 0->1; each rising edge increments the window count by exactly 1.
REQ-015 Window count SHALL saturate at 2^CNT_W-1 and set an internal sat flag; no wrap-around.
REQ-016 States: IDLE, MEASURE. IDLE->MEASURE when en=1; MEASURE->IDLE when en=0.
REQ-017 Entering MEASURE SHALL clear the gate counter, window count and sat flag; sq is preserved.
REQ-018 In MEASURE the gate counter SHALL count 0..GATE_CYCLES-1; on the cycle it equals GATE_CYCLES-1 the window closes.
REQ-019 On window close, freq_out and overflow SHALL be loaded on the next edge with the count/sat including any edge detected in the closing cycle; freq_valid pulses high for exactly that one cycle.
REQ-020 The cycle after close SHALL start a new window with count = 0 and sat = 0; no cycles are lost between windows.
REQ-021 en deasserted mid-window SHALL abort it: no freq_valid pulse; freq_out and overflow hold their last values.
REQ-022 In IDLE the comparator SHALL keep tracking samples, but edges are not counted.
REQ-023 freq_valid SHALL never be asserted in two consecutive cycles.

Reset
REQ-024 With rst_n=0 at a clk edge: state=IDLE, sq=0, gate counter=0, count=0, sat=0, freq_out=0, freq_valid=0, overflow=0.
REQ-025 Reset mid-window SHALL discard the partial window without a freq_valid pulse.

Configuration
REQ-026 Macro FREQ_METER_AVG_EN: when defined, freq_out SHALL be the floor mean (sum>>2) of the last four completed window counts, held in a 4-entry history cleared by reset; overflow is the OR of the four entries' sat flags.
REQ-027 When FREQ_METER_AVG_EN is defined, an en abort SHALL NOT clear the history.
REQ-028 When FREQ_METER_AVG_EN is not defined, freq_out SHALL be the raw last-window count and no history storage is instantiated.

Verification (GATE_CYCLES=1000, CNT_W=13, SAMPLE_W=8, HYST=4, sample_valid=1, averaging off unless stated)
REQ-029 Square wave 0/255, period 100 cycles, en=1 -> after the first full window, freq_out=10, freq_valid one-cycle pulse every 1000 cycles, overflow=0.
REQ-030 Sine wave toggling around 127..131 only (within +/-HYST) -> freq_out=0 each window.
REQ-031 Square wave, period 2 cycles, CNT_W=8 -> count saturates; freq_out=255, overflow=1.
REQ-032 en dropped at gate count 500, re-raised 20 cycles later -> no freq_valid pulse for the aborted window; freq_out holds its previous value; next pulse occurs 1000 cycles after re-enable.
REQ-033 rst_n=0 for 1 cycle mid-window -> all outputs 0 the next cycle; first freq_valid pulse 1000 cycles after en is seen high.
REQ-034 FREQ_METER_AVG_EN defined, window counts 10,10,10,14 -> freq_out sequence 2,5,7,11.
